// File: rtl/demapper.sv
// ---------------------------------------------------------------------------
// demapper : hard-decision 802.11a constellation demapper (receive path).
//
// Accepts one equalized constellation point per in_valid/in_ready handshake,
// slices I and Q to the nearest legal level for the selected modulation and
// streams the recovered coded bits out serially, x0 first, one per
// out_valid/out_ready handshake. bit_last flags the final bit of a symbol.
//
// Optional feature macro: DEMAPPER_ERRCNT_EN
//   defined   -> off-grid symbol detector, saturating err_cnt and err_clr
//   undefined -> err_cnt port absent, err_clr unused; data path unchanged
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   sym_in/mod valid
//   in_ready   block can accept a symbol this cycle
//   sym_in     [7:4] I, [3:0] Q, each sign-magnitude (bit 3 = negative)
//   mod        0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM
//   out_valid  bit_out valid
//   out_ready  downstream accepts bit_out
//   bit_out    recovered bit
//   bit_last   high with the final bit of a symbol
//   err_clr    synchronous clear of err_cnt (wins over an increment)
//   err_cnt    saturating off-grid symbol count (macro only)
// ---------------------------------------------------------------------------
module demapper #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       sym_in,
    input  logic [1:0]       mod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             bit_out,
    output logic             bit_last,
    input  logic             err_clr
`ifdef DEMAPPER_ERRCNT_EN
    ,
    output logic [ERR_W-1:0] err_cnt
`endif
);

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_bits;      // remaining bits, current bit at [0]
    logic [2:0]  r_cnt;       // bits left including the one on bit_out
    logic [5:0]  w_bits_in;
    logic [2:0]  w_n;
    logic        w_last, w_accept, w_adv;

    logic        w_si, w_sq;
    logic [2:0]  w_mi, w_mq;
    assign w_si = sym_in[7];
    assign w_mi = sym_in[6:4];
    assign w_sq = sym_in[3];
    assign w_mq = sym_in[2:0];

    // Slicer: Gray-coded level decisions. The sign alone decides x0/x3,
    // so +0 slices positive and -0 negative. Ties resolve to the larger
    // level, which falls out of using only the upper magnitude bits.
    always_comb begin
        w_bits_in = '0;
        w_n       = 3'd1;
        case (mod)
            2'd0: begin
                w_bits_in[0] = ~w_si;
                w_n          = 3'd1;
            end
            2'd1: begin
                w_bits_in[0] = ~w_si;
                w_bits_in[1] = ~w_sq;
                w_n          = 3'd2;
            end
            2'd2: begin
                w_bits_in[0] = ~w_si;
                w_bits_in[1] = ~(w_mi[2] | w_mi[1]);
                w_bits_in[2] = ~w_sq;
                w_bits_in[3] = ~(w_mq[2] | w_mq[1]);
                w_n          = 3'd4;
            end
            default: begin
                w_bits_in[0] = ~w_si;
                w_bits_in[1] = ~w_mi[2];
                w_bits_in[2] = w_mi[2] ^ w_mi[1];
                w_bits_in[3] = ~w_sq;
                w_bits_in[4] = ~w_mq[2];
                w_bits_in[5] = w_mq[2] ^ w_mq[1];
                w_n          = 3'd6;
            end
        endcase
    end

    assign w_last   = (r_cnt == 3'd1);
    assign w_accept = in_valid & in_ready;
    assign w_adv    = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last && out_ready && !in_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic; the last-bit term in in_ready lets the next symbol
    // load on the same edge the final bit leaves (no bubble).
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        bit_last  = 1'b0;
        bit_out   = r_bits[0];
        case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_SHIFT: begin
                out_valid = 1'b1;
                bit_last  = w_last;
                in_ready  = w_last & out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Shift register: load wins over advance (both happen on the last bit)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bits <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_bits <= w_bits_in;
            r_cnt  <= w_n;
        end else if (w_adv) begin
            r_bits <= {1'b0, r_bits[5:1]};
            r_cnt  <= r_cnt - 3'd1;
        end
    end

`ifdef DEMAPPER_ERRCNT_EN
    logic             w_offgrid;
    logic [ERR_W-1:0] r_err;

    // Legal magnitudes: BPSK/QPSK 1 (BPSK Q must be zero), 16-QAM 1/3,
    // 64-QAM any odd value.
    always_comb begin
        case (mod)
            2'd0:    w_offgrid = (w_mi != 3'd1) | (w_mq != 3'd0);
            2'd1:    w_offgrid = (w_mi != 3'd1) | (w_mq != 3'd1);
            2'd2:    w_offgrid = ~w_mi[0] | w_mi[2] | ~w_mq[0] | w_mq[2];
            default: w_offgrid = ~w_mi[0] | ~w_mq[0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= '0;
        else if (err_clr)
            r_err <= '0;
        else if (w_accept && w_offgrid && (r_err != {ERR_W{1'b1}}))
            r_err <= r_err + {{(ERR_W-1){1'b0}}, 1'b1};
    end

    assign err_cnt = r_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_demapper.sv
// ---------------------------------------------------------------------------
// tb_demapper : self-checking bench for demapper.
// Reference model: per-axis nearest-level search plus the 802.11a Gray
// tables; expected bits are queued per symbol and popped on each output
// handshake. A negedge monitor compares every cycle.
// ---------------------------------------------------------------------------
module tb_demapper;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic       bit_out, bit_last, err_clr;
    logic [7:0] sym_in;
    logic [1:0] mod;
`ifdef DEMAPPER_ERRCNT_EN
    logic [1:0] err_cnt;
`endif

    demapper #(.ERR_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sym_in(sym_in), .mod(mod), .out_valid(out_valid),
        .out_ready(out_ready), .bit_out(bit_out), .bit_last(bit_last),
        .err_clr(err_clr)
`ifdef DEMAPPER_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Nearest of levels 1,3,..,2*nlev-1; ties go to the larger level.
    function automatic int lvl(input int mag, input int nlev);
        int best = 1;
        for (int k = 0; k < nlev; k++) begin
            int lv = 2 * k + 1;
            if (iabs(mag - lv) <= iabs(mag - best)) best = lv;
        end
        return best;
    endfunction

    function automatic int mdl_n(input logic [1:0] m);
        case (m)
            2'd0: return 1;
            2'd1: return 2;
            2'd2: return 4;
            default: return 6;
        endcase
    endfunction

    // Returned vector holds x0 at bit 0.
    function automatic logic [5:0] mdl_bits(input logic [7:0] s, input logic [1:0] m);
        logic [1:0] t16 [4];
        logic [2:0] t64 [8];
        logic [1:0] gi2, gq2;
        logic [2:0] gi3, gq3;
        logic [5:0] r;
        int si, sq, ai, aq;
        t16 = '{2'b00, 2'b01, 2'b11, 2'b10};                 // -3,-1,+1,+3
        t64 = '{3'b000, 3'b001, 3'b011, 3'b010,
                3'b110, 3'b111, 3'b101, 3'b100};             // -7 .. +7
        si = s[7] ? -1 : 1;
        sq = s[3] ? -1 : 1;
        r  = '0;
        case (m)
            2'd0: r[0] = (si > 0);
            2'd1: begin r[0] = (si > 0); r[1] = (sq > 0); end
            2'd2: begin
                ai = si * lvl(int'(s[6:4]), 2);
                aq = sq * lvl(int'(s[2:0]), 2);
                gi2 = t16[(ai + 3) / 2];
                gq2 = t16[(aq + 3) / 2];
                r[0] = gi2[1]; r[1] = gi2[0];
                r[2] = gq2[1]; r[3] = gq2[0];
            end
            default: begin
                ai = si * lvl(int'(s[6:4]), 4);
                aq = sq * lvl(int'(s[2:0]), 4);
                gi3 = t64[(ai + 7) / 2];
                gq3 = t64[(aq + 7) / 2];
                r[0] = gi3[2]; r[1] = gi3[1]; r[2] = gi3[0];
                r[3] = gq3[2]; r[4] = gq3[1]; r[5] = gq3[0];
            end
        endcase
        return r;
    endfunction

    function automatic logic mdl_off(input logic [7:0] s, input logic [1:0] m);
        int mi, mq;
        mi = int'(s[6:4]);
        mq = int'(s[2:0]);
        case (m)
            2'd0: return (mi != 1) || (mq != 0);
            2'd1: return (mi != 1) || (mq != 1);
            2'd2: return (lvl(mi, 2) != mi) || (lvl(mq, 2) != mq);
            default: return (lvl(mi, 4) != mi) || (lvl(mq, 4) != mq);
        endcase
    endfunction

    typedef struct packed { logic b; logic l; } ebit_t;
    ebit_t q[$];
    int    m_err = 0;
    logic  s_acc = 0, s_pop = 0, s_clr = 0;
    logic [7:0] s_sym;
    logic [1:0] s_mod;

    // Compare process: sample away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            s_acc = 0; s_pop = 0; s_clr = 0;
        end else begin
            logic exp_rdy;
            exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            if (q.size() != 0) begin
                chk("bit_out", {31'd0, bit_out}, {31'd0, q[0].b});
                chk("bit_last", {31'd0, bit_last}, {31'd0, q[0].l});
            end
`ifdef DEMAPPER_ERRCNT_EN
            chk("err_cnt", {30'd0, err_cnt}, m_err);
`endif
            s_acc = in_valid && exp_rdy;
            s_pop = (q.size() != 0) && out_ready;
            s_sym = sym_in;
            s_mod = mod;
            s_clr = err_clr;
        end
    end

    // Model state update on the active edge, from values sampled at negedge.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_err = 0;
        end else begin
            if (s_pop) void'(q.pop_front());
            if (s_acc) begin
                logic [5:0] bv;
                int n;
                ebit_t e;
                bv = mdl_bits(s_sym, s_mod);
                n  = mdl_n(s_mod);
                for (int i = 0; i < n; i++) begin
                    e.b = bv[i];
                    e.l = (i == n - 1);
                    q.push_back(e);
                end
            end
            if (s_clr) m_err = 0;
            else if (s_acc && mdl_off(s_sym, s_mod) && m_err < 3) m_err++;
        end
    end

    // Random out_ready generator
    bit rnd_or = 0;
    always @(posedge clk) begin
        #1;
        if (rnd_or) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Present a symbol until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] s, input logic [1:0] m, input bit hold);
        int n = 0;
        in_valid = 1; sym_in = s; mod = m;
        do begin
            @(posedge clk);
            n++;
        end while (!s_acc && n < 200);
        if (n >= 200) chk("accept_timeout", 32'd1, 32'd0);
        #1;
        if (!hold) in_valid = 0;
        sym_in = 8'($urandom);
        mod    = 2'($urandom);
    endtask

    initial begin
        rst = 1; in_valid = 0; sym_in = 0; mod = 0; out_ready = 1; err_clr = 0;

        // Pin the model with hand-computed values
        chk("pin_64qam_3F", {26'd0, mdl_bits(8'h3F, 2'd3)}, 32'h07);
        chk("pin_64qam_71", {26'd0, mdl_bits(8'h71, 2'd3)}, 32'h19);
        chk("pin_16qam_2A", {26'd0, mdl_bits(8'h2A, 2'd2)}, 32'h01);
        chk("pin_bpsk_10", {26'd0, mdl_bits(8'h10, 2'd0)}, 32'h01);
        chk("pin_bpsk_90", {26'd0, mdl_bits(8'h90, 2'd0)}, 32'h00);
        chk("pin_bpsk_pz", {26'd0, mdl_bits(8'h00, 2'd0)}, 32'h01);
        chk("pin_off_22", {31'd0, mdl_off(8'h22, 2'd1)}, 32'd1);
        chk("pin_off_2A", {31'd0, mdl_off(8'h2A, 2'd2)}, 32'd1);
        chk("pin_off_3F", {31'd0, mdl_off(8'h3F, 2'd3)}, 32'd0);

        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_bit_out", {31'd0, bit_out}, 32'd0);
        chk("rst_bit_last", {31'd0, bit_last}, 32'd0);
`ifdef DEMAPPER_ERRCNT_EN
        chk("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // BPSK back-to-back
        send(8'h10, 2'd0, 1);
        send(8'h90, 2'd0, 0);
        repeat (3) @(posedge clk);
        #1;

        // 64-QAM followed by a symbol loaded on the 6th-bit edge
        send(8'h3F, 2'd3, 1);
        send(8'h10, 2'd0, 0);
        repeat (4) @(posedge clk);
        #1;

        // Reset during x2 of a 64-QAM symbol
        send(8'h3F, 2'd3, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_bit_last", {31'd0, bit_last}, 32'd0);
        @(posedge clk); #1 rst = 0;
`ifdef DEMAPPER_ERRCNT_EN
        chk("midrst_err_cnt", {30'd0, err_cnt}, 32'd0);
`endif
        send(8'h3F, 2'd3, 0);
        repeat (7) @(posedge clk);
        #1;

        // 16-QAM off-grid symbol
        send(8'h2A, 2'd2, 0);
`ifdef DEMAPPER_ERRCNT_EN
        chk("16qam_err_cnt", {30'd0, err_cnt}, 32'd1);
`endif
        repeat (5) @(posedge clk);
        #1;

        // Backpressure after bit 2 is presented
        send(8'h71, 2'd3, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1;
        repeat (6) @(posedge clk);
        #1;

        // Counter saturation and clear priority
        for (int i = 0; i < 5; i++) send(8'h22, 2'd1, i < 4);
        repeat (4) @(posedge clk);
        #1;
`ifdef DEMAPPER_ERRCNT_EN
        chk("sat_err_cnt", {30'd0, err_cnt}, 32'd3);
`endif
        err_clr = 1;
        send(8'h22, 2'd1, 0);
        err_clr = 0;
`ifdef DEMAPPER_ERRCNT_EN
        chk("clr_err_cnt", {30'd0, err_cnt}, 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        rnd_or = 1;
        for (int k = 0; k < 300; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            #1;
            err_clr = ($urandom_range(0, 19) == 0);
            send(8'($urandom), 2'($urandom), $urandom_range(0, 1) == 1);
            err_clr = 0;
        end
        in_valid = 0;
        rnd_or = 0;
        out_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/demapper.md
# demapper

Hard-decision constellation demapper for the 802.11a receive path: the inverse of the transmit mapper. Accepts one equalized constellation point per handshake, slices I and Q to the nearest 802.11a level for the selected modulation, and emits the recovered coded bits serially, one bit per cycle, toward the deinterleaver. The block is a two-state FSM with a shift register, valid/ready on both sides, and an optional off-grid symbol counter.

## Interface
- ERR_W, 16, width of the off-grid counter (only with DEMAPPER_ERRCNT_EN)
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous and active-high
- in_valid  input  1  sym_in/mod valid
- in_ready  output  1  block can accept a symbol this cycle
- sym_in  input  8  [7:4] I, [3:0] Q; each 4-bit sign-magnitude (bit 3 sign, 1 = negative; [2:0] magnitude 0..7)
- mod  input  2  0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM; sampled with sym_in
- out_valid  output  1  bit_out valid
- out_ready  input  1  downstream accepts bit_out
- bit_out  output  1  recovered bit
- bit_last  output  1  high with the final bit of a symbol
- err_clr  input  1  synchronous clear of err_cnt
- err_cnt  output  ERR_W  saturating off-grid symbol count (only with DEMAPPER_ERRCNT_EN)

## Operation
- Bits per symbol N: BPSK 1, QPSK 2, 16-QAM 4, 64-QAM 6. Per axis: s = sign, m = magnitude.
- Slicing (ties round to the larger level; level index = m[2:1]):
  - BPSK: x0 = ~sI; Q ignored.
  - QPSK: x0 = ~sI, x1 = ~sQ.
  - 16-QAM: x0 = ~sI, x1 = ~(mI[2]|mI[1]); x2, x3 are the same functions of Q.
  - 64-QAM: x0 = ~sI, x1 = ~mI[2], x2 = mI[2]^mI[1]; x3..x5 are the same functions of Q.
  - Sign is the decision for +0/−0: 0x0 gives 1, 0x8 gives 0.
- Bit order: x0 first through x(N−1); bit_last on x(N−1).
- FSM:
  - IDLE: in_ready = 1. On in_valid, latch the sliced bits and N, then go to SHIFT.
  - SHIFT: out_valid = 1. On out_ready, advance by one bit.
  - On the last bit with out_ready: if in_valid, load the next symbol and stay in SHIFT; otherwise return to IDLE.
- in_ready = IDLE, or (SHIFT & last bit & out_ready). This gives zero-bubble back-to-back symbols.
- mod and sym_in are ignored unless a symbol is being accepted.
- Off-grid: a symbol is off-grid if any axis magnitude is not a legal level:
  - BPSK: mI ≠ 1, or Q ≠ 0x0/0x8.
  - QPSK: m ≠ 1 on either axis.
  - 16-QAM: m ∉ {1,3}.
  - 64-QAM: m even.
  - The check is evaluated at acceptance.

## Timing
- Reset values: FSM IDLE, in_ready 1, out_valid 0, bit_out 0, bit_last 0, err_cnt 0.
- Latency: a symbol accepted at edge k presents x0 from k+1. Bit i changes only on an edge where out_valid & out_ready.
- While out_ready = 0: bit_out, bit_last and out_valid hold, and in_ready = 0 except in IDLE.
- Throughput is N cycles per symbol with continuous out_ready. For BPSK, out_valid and bit_last stay high continuously.
- rst mid-symbol: the remaining bits are discarded, and outputs return to reset values asynchronously.
- err_cnt increments on the edge that accepts an off-grid symbol and saturates at 2^ERR_W−1. err_clr takes priority over a same-cycle increment (result 0).

## Configuration
- DEMAPPER_ERRCNT_EN defined: the off-grid detector, err_cnt register and err_clr are compiled in.
- DEMAPPER_ERRCNT_EN undefined: err_cnt and the ERR_W logic are absent, err_clr is left unconnected internally, and the data path and FSM are bit-identical.

## Test plan
- BPSK: 0x10 then 0x90 back-to-back, out_ready = 1 → bit_out 1 then 0, bit_last high on both, in_ready never drops, err_cnt 0.
- 64-QAM: 0x3F (I +3, Q −7) → bits 1,1,1,0,0,0; bit_last only on the 6th; next symbol accepted on the same edge as the 6th bit.
- 16-QAM noisy: 0x2A (I +2, Q −2) → bits 1,0,0,0 (+3, −3), err_cnt 0 → 1.
- Backpressure: 64-QAM 0x71, out_ready low for 3 cycles after bit 2 → bit 2 held stable, in_ready 0, total 6 bits, none duplicated.
- Reset mid-shift: rst asserted during bit 3 of a 64-QAM symbol → out_valid 0 immediately; after release in_ready 1, err_cnt 0, next symbol starts at x0.
- Counter (ERR_W = 2): 5 off-grid QPSK 0x22 → err_cnt 3 (saturated); err_clr with a simultaneous off-grid symbol → 0. With the macro undefined, the same stimulus produces identical bit_out.
